vga_ring_engine: RTL
====================

// Module: vga_ring_engine
// PURPOSE
// - Parametrised, pipelined concentric-pattern pixel engine for the Tiny VGA PMOD (RGB222).
// - Consumes hpos/vpos/display_on/hsync/vsync from hvsync_generator.
// - Drives registered colour and sync outputs, with selectable distance metric, speed, direction and freeze.
// - Controls take effect only at frame boundaries.
// - Optional bouncing centre.
// PARAMETERS
// - H_ACTIVE  640  visible pixels per line
// - V_ACTIVE  480  visible lines per frame
// - CX0       320  reset/fixed centre x
// - CY0       240  reset/fixed centre y
// - SPEED_W   2    width of speed input; step per frame = speed value
// - MARGIN    64   bounce keep-out from screen edge (BOUNCE_EN only)
// PORTS
// - clk         in   1        pixel clock
// - rst_n       in   1        asynchronous reset, active low
// - hpos        in   10       current pixel x
// - vpos        in   10       current pixel y
// - display_on  in   1        visible-area flag
// - hsync_in    in   1        hsync from generator
// - vsync_in    in   1        vsync from generator
// - speed       in   SPEED_W  animation step per frame; 0 = static
// - direction   in   1        0 = rings move outward, 1 = inward
// - mode        in   2        0 = round (max+min/2), 1 = diamond (|x|+|y|), 2 = square (max), 3 = checker (|x|^|y|)
// - freeze      in   1        1 = hold frame counter and centre
// - r_out       out  2        red
// - g_out       out  2        green
// - b_out       out  2        blue
// - hsync_out   out  1        hsync, delayed to align with colour
// - vsync_out   out  1        vsync, delayed to align with colour
// - frame_out   out  10       current frame counter (debug)
// BEHAVIOUR
// - Reset (async, rst_n = 0) clears all of the following to 0: all outputs, pipeline registers, frame counter and shadow controls.
// - Reset sets centre to (CX0, CY0) and both bounce FSMs to INC.
// - Frame start (fs) = cycle with hpos == 0 && vpos == 0.
// - On fs, speed/direction/mode/freeze are latched into shadow registers. Mid-frame changes are ignored until the next fs.
// - On fs with shadow freeze == 0: frame <= frame + shadow speed (10-bit, wraps mod 1024).
// - The updated frame is used from the cycle after fs; fs itself still uses the old values.
// - Stage 1 (registered): compute centre-relative signed x/y and abs values.
//   - x = hpos - cx, y = vpos - cy; 11-bit signed.
//   - |x|, |y| are 10-bit.
// - Stage 1 also computes metric m (11-bit) per shadow mode:
//   - round: max + (min >> 1)
//   - diamond: |x| + |y|
//   - square: max
//   - checker: |x| ^ |y|
// - Stage 2 (registered): a = m[7:0] +/- {frame[6:0], 1'b0} mod 256 (+ when direction = 0).
//   - r = a[5:4], g = a[6:5], b = a[7:6], each ANDed with the delayed display_on.
// - Latency: exactly 2 clk from hpos/vpos/display_on/hsync_in/vsync_in to outputs.
//   - The syncs pass through a matching 2-deep delay line.
// - After reset the first 2 output cycles are 0 regardless of inputs.
// - Outside the active area (display_on = 0) colours are 0; syncs still follow input.
// - Reset mid-frame: outputs go to 0 immediately; animation resumes from frame 0 at the next fs.
// CONFIGURATION
// - BOUNCE_EN defined:
//   - Independent 2-state FSM per axis (INC/DEC).
//   - On fs with freeze == 0, the centre moves 1 px per frame along each axis.
//   - x: INC->DEC when cx == H_ACTIVE-1-MARGIN (that fs still steps, in the new direction: cx-1);
//     DEC->INC when cx == MARGIN (cx+1).
//   - y: same rule with V_ACTIVE.
// - BOUNCE_EN undefined:
//   - Centre is constant (CX0, CY0); no FSM logic is synthesised.
// TESTING
// - Reset: hold rst_n = 0 with arbitrary inputs -> all outputs 0, frame_out = 0.
//   Release -> first 2 cycles still 0.
// - Latency/round: mode 0, frame 0, pixel (368,240) visible -> r=11 g=01 b=00 exactly 2 clk later.
//   hsync_out/vsync_out equal the inputs delayed by 2 clk.
// - Metric select at (340,260):
//   - mode 0 -> r=01 g=00 b=00
//   - mode 1 -> r=10 g=01 b=00
//   - mode 2 -> r=01 g=00 b=00
//   - mode 3 -> all 0
// - Animation: speed = 1, 8 frames -> frame_out = 8, pixel (368,240):
//   - direction 0 -> r=00 g=10 b=01
//   - direction 1 -> r=10 g=01 b=00
//   - speed changed mid-frame -> frame step unchanged until next fs
//   - freeze = 1 -> frame_out constant
// - Wrap: frame = 1020, speed = 3 -> next fs frame_out = 1023, then 2 (mod 1024).
// - BOUNCE_EN: default params -> cx = 575 after 255 frames, 574 at frame 256.
//   cy = 415 after 175 frames, 414 at frame 176.
//   Without BOUNCE_EN -> centre stays (320,240).

Source files
------------

// File: rtl/vga_ring_engine.sv
// vga_ring_engine: 2-stage concentric-ring RGB222 pixel engine for the Tiny VGA PMOD.
// Define BOUNCE_EN to make the ring centre bounce inside the MARGIN keep-out.
module vga_ring_engine #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CX0      = 320,
  parameter int CY0      = 240,
  parameter int SPEED_W  = 2,
  parameter int MARGIN   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               display_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [SPEED_W-1:0] speed,
  input  logic               direction,
  input  logic [1:0]         mode,
  input  logic               freeze,
  output logic [1:0]         r_out,
  output logic [1:0]         g_out,
  output logic [1:0]         b_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [9:0]         frame_out
);

  if (CX0 >= H_ACTIVE || CY0 >= V_ACTIVE ||
      2 * MARGIN >= V_ACTIVE || SPEED_W > 10) begin : g_cfg_err
    $error("vga_ring_engine: inconsistent parameters");
  end

  logic               w_fs;
  logic [SPEED_W-1:0] r_speed;
  logic               r_dir;
  logic [1:0]         r_mode;
  logic               r_freeze;
  logic [9:0]         w_cx;
  logic [9:0]         w_cy;

  assign w_fs = (hpos == 10'd0) && (vpos == 10'd0);

  // Shadows and frame step both see the pre-fs values on the fs cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed   <= '0;
      r_dir     <= 1'b0;
      r_mode    <= 2'd0;
      r_freeze  <= 1'b0;
      frame_out <= 10'd0;
    end else if (w_fs) begin
      r_speed  <= speed;
      r_dir    <= direction;
      r_mode   <= mode;
      r_freeze <= freeze;
      if (!r_freeze)
        frame_out <= frame_out + 10'(r_speed);
    end
  end

`ifdef BOUNCE_EN
  typedef enum logic {INC, DEC} bdir_e;

  localparam logic [9:0] X_HI = 10'(H_ACTIVE - 1 - MARGIN);
  localparam logic [9:0] Y_HI = 10'(V_ACTIVE - 1 - MARGIN);
  localparam logic [9:0] LO   = 10'(MARGIN);

  bdir_e      r_xs;
  bdir_e      r_ys;
  logic [9:0] r_cx;
  logic [9:0] r_cy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs <= INC;
      r_ys <= INC;
      r_cx <= 10'(CX0);
      r_cy <= 10'(CY0);
    end else if (w_fs && !r_freeze) begin
      unique case (r_xs)
        INC: if (r_cx == X_HI) begin
          r_xs <= DEC;
          r_cx <= r_cx - 10'd1;
        end else r_cx <= r_cx + 10'd1;
        DEC: if (r_cx == LO) begin
          r_xs <= INC;
          r_cx <= r_cx + 10'd1;
        end else r_cx <= r_cx - 10'd1;
      endcase
      unique case (r_ys)
        INC: if (r_cy == Y_HI) begin
          r_ys <= DEC;
          r_cy <= r_cy - 10'd1;
        end else r_cy <= r_cy + 10'd1;
        DEC: if (r_cy == LO) begin
          r_ys <= INC;
          r_cy <= r_cy + 10'd1;
        end else r_cy <= r_cy - 10'd1;
      endcase
    end
  end

  assign w_cx = r_cx;
  assign w_cy = r_cy;
`else
  assign w_cx = 10'(CX0);
  assign w_cy = 10'(CY0);
`endif

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [9:0]  w_ax;
  logic [9:0]  w_ay;
  logic        w_ge;
  logic [7:0]  w_m;

  assign w_x  = {1'b0, hpos} - {1'b0, w_cx};
  assign w_y  = {1'b0, vpos} - {1'b0, w_cy};
  assign w_ax = w_x[10] ? 10'(-w_x) : w_x[9:0];
  assign w_ay = w_y[10] ? 10'(-w_y) : w_y[9:0];
  assign w_ge = w_ax >= w_ay;

  // Only m[7:0] reaches the colour stage, so the metric is kept mod 256.
  always_comb begin
    w_m = 8'd0;
    unique case (r_mode)
      2'd0: w_m = w_ge ? w_ax[7:0] + w_ay[8:1]
                       : w_ay[7:0] + w_ax[8:1];
      2'd1: w_m = w_ax[7:0] + w_ay[7:0];
      2'd2: w_m = w_ge ? w_ax[7:0] : w_ay[7:0];
      2'd3: w_m = w_ax[7:0] ^ w_ay[7:0];
    endcase
  end

  logic [7:0] r_m;
  logic       r_de;
  logic       r_hs;
  logic       r_vs;
  logic [7:0] w_off;
  logic [3:0] w_a;

  assign w_off = {frame_out[6:0], 1'b0};
  assign w_a   = r_dir ? 4'((r_m - w_off) >> 4)
                       : 4'((r_m + w_off) >> 4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= 8'd0;
      r_de      <= 1'b0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_out     <= 2'd0;
      g_out     <= 2'd0;
      b_out     <= 2'd0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      r_m       <= w_m;
      r_de      <= display_on;
      r_hs      <= hsync_in;
      r_vs      <= vsync_in;
      r_out     <= w_a[1:0] & {2{r_de}};
      g_out     <= w_a[2:1] & {2{r_de}};
      b_out     <= w_a[3:2] & {2{r_de}};
      hsync_out <= r_hs;
      vsync_out <= r_vs;
    end
  end

endmodule
